// File: rtl/signed_bcd_conv_pkg.sv
// sbcd_pkg: shared types and helpers for the signed binary-to-BCD converter.
//   sbcd_state_t  : converter FSM states
//   BCD_W         : bits per packed BCD digit
//   digits_needed : decimal digit count of 2^w-1, used to size DIGITS
package sbcd_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sbcd_state_t;

  // Smallest d with 10^d >= 2^w, i.e. the digit count of 2^w-1.
  function automatic int digits_needed(input int w);
    logic [127:0] pow2;
    logic [127:0] p;
    int           d;
    pow2 = 128'd1 << w;
    p    = 128'd1;
    d    = 0;
    for (int i = 0; i < 40; i++) begin
      if (p < pow2) begin
        p = p * 128'd10;
        d = d + 1;
      end else begin
        d = d;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/signed_bcd_conv_if.sv
// signed_bcd_conv_if: valid/ready bundle between the datapath result
// registers (master) and the signed BCD converter (slave).
//   in_valid/in_ready/din/signed_mode : request side
//   out_valid/out_ready/bcd/sign/digit_en : result side
interface signed_bcd_conv_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  import sbcd_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  logic [WIDTH-1:0]          din;
  logic                      signed_mode;
  logic                      out_valid;
  logic                      out_ready;
  logic [BCD_W*DIGITS-1:0]   bcd;
  logic                      sign;
  logic [DIGITS-1:0]         digit_en;

  modport master (
    output in_valid, din, signed_mode, out_ready,
    input  in_ready, out_valid, bcd, sign, digit_en
  );

  modport slave (
    input  in_valid, din, signed_mode, out_ready,
    output in_ready, out_valid, bcd, sign, digit_en
  );

endinterface

// File: rtl/signed_bcd_conv_digit_adj.sv
// bcd_digit_adj: double-dabble correction cell. Adds 3 to a BCD digit of
// 5 or more so that the following left shift carries into the next digit.
//   d : current digit
//   q : corrected digit
module bcd_digit_adj (
  input  logic [3:0] d,
  output logic [3:0] q
);

  // Add-3-if-at-least-5 correction.
  always_comb begin
    q = d;
    if (d >= 4'd5) begin
      q = d + 4'd3;
    end else begin
      q = d;
    end
  end

endmodule

// File: rtl/signed_bcd_conv.sv
// signed_bcd_conv: sequential WIDTH-bit binary to sign-and-magnitude packed
// BCD converter with a leading-zero mask for the seven-segment driver.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of signed_bcd_conv_if (request in, result out)
// One conversion takes WIDTH shift cycles; the result is held until accepted.
module signed_bcd_conv
  import sbcd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  signed_bcd_conv_if.slave    bus
);

  localparam int BW = BCD_W * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  if (DIGITS < digits_needed(WIDTH)) begin : g_digits_check
    $error("signed_bcd_conv: DIGITS too small for WIDTH");
  end

  sbcd_state_t         state_r;
  logic [WIDTH-1:0]    mag_r;
  logic [BW-1:0]       bcd_r;
  logic                sign_r;
  logic [DIGITS-1:0]   en_r;
  logic [CW-1:0]       cnt_r;
  logic                out_valid_r;

  logic                neg_s;
  logic [WIDTH-1:0]    mag_in_s;
  logic [BW-1:0]       adj_s;
  logic [BW+WIDTH-1:0] cat_s;

  // Digit i is significant when any digit at or above i is nonzero;
  // digit 0 is always shown so a zero value displays as "0".
  function automatic logic [DIGITS-1:0] lead_mask(input logic [BW-1:0] b);
    logic [DIGITS-1:0] m;
    logic              seen;
    m    = '0;
    seen = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (b[i*BCD_W +: BCD_W] != 4'd0) begin
        seen = 1'b1;
      end else begin
        seen = seen;
      end
      m[i] = seen;
    end
    m[0] = 1'b1;
    return m;
  endfunction

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (bcd_r[g*BCD_W +: BCD_W]),
      .q (adj_s[g*BCD_W +: BCD_W])
    );
  end

  // One double-dabble step: corrected digits and magnitude shift left together.
  assign cat_s = {adj_s, mag_r} << 1'b1;

  // Magnitude of the incoming value; the WIDTH-bit negate maps the most
  // negative input onto 2^(WIDTH-1) exactly.
  always_comb begin
    neg_s    = bus.signed_mode & bus.din[WIDTH-1];
    mag_in_s = bus.din;
    if (neg_s) begin
      mag_in_s = ~bus.din + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      mag_in_s = bus.din;
    end
  end

  // Converter FSM with registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      mag_r       <= '0;
      bcd_r       <= '0;
      sign_r      <= 1'b0;
      en_r        <= '0;
      cnt_r       <= '0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          out_valid_r <= 1'b0;
          if (bus.in_valid) begin
            sign_r  <= neg_s;
            mag_r   <= mag_in_s;
            bcd_r   <= '0;
            cnt_r   <= CW'(WIDTH);
            state_r <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_r <= cat_s[BW+WIDTH-1:WIDTH];
          mag_r <= cat_s[WIDTH-1:0];
          cnt_r <= cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            en_r        <= lead_mask(cat_s[BW+WIDTH-1:WIDTH]);
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_r == IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.bcd       = bcd_r;
  assign bus.sign      = sign_r;
  assign bus.digit_en  = en_r;

endmodule

// File: tb/tb_signed_bcd_conv.sv
// tb_signed_bcd_conv: directed and reference-model checks of signed_bcd_conv
// at WIDTH=16/DIGITS=5 and WIDTH=8/DIGITS=3.
module tb_signed_bcd_conv;

  logic clk = 1'b0;
  logic rst_n;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  signed_bcd_conv_if #(.WIDTH(16), .DIGITS(5)) bus16 ();
  signed_bcd_conv_if #(.WIDTH(8),  .DIGITS(3)) bus8  ();

  signed_bcd_conv #(.WIDTH(16), .DIGITS(5)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  signed_bcd_conv #(.WIDTH(8), .DIGITS(3)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit w8, input logic iv, input logic [15:0] d,
                       input logic sm, input logic ordy);
    if (w8) begin
      bus8.in_valid = iv; bus8.din = d[7:0]; bus8.signed_mode = sm; bus8.out_ready = ordy;
    end else begin
      bus16.in_valid = iv; bus16.din = d; bus16.signed_mode = sm; bus16.out_ready = ordy;
    end
  endtask

  task automatic get_out(input bit w8, output logic ov, output logic ir,
                         output logic [19:0] b, output logic sg, output logic [4:0] en);
    if (w8) begin
      ov = bus8.out_valid; ir = bus8.in_ready; b = {8'd0, bus8.bcd};
      sg = bus8.sign; en = {2'b00, bus8.digit_en};
    end else begin
      ov = bus16.out_valid; ir = bus16.in_ready; b = bus16.bcd;
      sg = bus16.sign; en = bus16.digit_en;
    end
  endtask

  // Reference: decimal digits by repeated division, independent of shift-add-3.
  function automatic void model(input bit w8, input logic [15:0] d, input logic sm,
                                output logic [19:0] b, output logic sg, output logic [4:0] en);
    int w  = w8 ? 8 : 16;
    int nd = w8 ? 3 : 5;
    int v, mag, hi, dig;
    v   = int'(d) & ((1 << w) - 1);
    sg  = sm && (v >= (1 << (w - 1)));
    mag = sg ? ((1 << w) - v) : v;
    b = '0; en = '0; hi = 0;
    for (int i = 0; i < nd; i++) begin
      dig = mag % 10;
      b[i*4 +: 4] = 4'(dig);
      if (dig != 0) hi = i;
      mag = mag / 10;
    end
    for (int i = 0; i <= hi; i++) en[i] = 1'b1;
  endfunction

  task automatic start(input bit w8, input logic [15:0] d, input logic sm, input logic ordy);
    logic ov, ir, sg; logic [19:0] b; logic [4:0] en;
    get_out(w8, ov, ir, b, sg, en);
    chk("in_ready_idle", 64'(ir), 64'd1);
    drive(w8, 1'b1, d, sm, ordy);
    tick();
    drive(w8, 1'b0, 16'h0000, 1'b0, ordy);
  endtask

  task automatic wait_done(input bit w8, output int lat);
    logic ov, ir, sg; logic [19:0] b; logic [4:0] en;
    lat = 0;
    do begin
      tick();
      lat++;
      get_out(w8, ov, ir, b, sg, en);
    end while (!ov && lat < 40);
  endtask

  task automatic check_res(input string tag, input bit w8, input logic [19:0] eb,
                           input logic es, input logic [4:0] een);
    logic ov, ir, sg; logic [19:0] b; logic [4:0] en;
    get_out(w8, ov, ir, b, sg, en);
    chk({tag, "_ov"},   64'(ov), 64'd1);
    chk({tag, "_ir"},   64'(ir), 64'd0);
    chk({tag, "_bcd"},  64'(b),  64'(eb));
    chk({tag, "_sign"}, 64'(sg), 64'(es));
    chk({tag, "_en"},   64'(en), 64'(een));
  endtask

  task automatic finish_hs(input string tag, input bit w8);
    logic ov, ir, sg; logic [19:0] b; logic [4:0] en;
    drive(w8, 1'b0, 16'h0000, 1'b0, 1'b1);
    tick();
    get_out(w8, ov, ir, b, sg, en);
    chk({tag, "_hs_ov"}, 64'(ov), 64'd0);
    chk({tag, "_hs_ir"}, 64'(ir), 64'd1);
  endtask

  task automatic conv(input string tag, input bit w8, input logic [15:0] d, input logic sm,
                      input logic [19:0] eb, input logic es, input logic [4:0] een);
    int lat;
    start(w8, d, sm, 1'b1);
    wait_done(w8, lat);
    chk({tag, "_lat"}, 64'(lat), w8 ? 64'd8 : 64'd16);
    check_res(tag, w8, eb, es, een);
    finish_hs(tag, w8);
  endtask

  initial begin
    logic ov, ir, sg; logic [19:0] b; logic [4:0] en;
    logic [19:0] mb; logic ms; logic [4:0] men;
    logic [15:0] rd; logic rs;
    int lat;

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
    tick();
    get_out(1'b0, ov, ir, b, sg, en);
    chk("rst_ov", 64'(ov), 64'd0);
    chk("rst_ir", 64'(ir), 64'd1);
    chk("rst_bcd", 64'(b), 64'd0);
    chk("rst_sign", 64'(sg), 64'd0);
    chk("rst_en", 64'(en), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    get_out(1'b1, ov, ir, b, sg, en);
    chk("rst8_ir", 64'(ir), 64'd1);

    // Directed vectors, hand-computed expectations.
    conv("neg1",    1'b0, 16'hFFFF, 1'b1, 20'h00001, 1'b1, 5'b00001);
    conv("mostneg", 1'b0, 16'h8000, 1'b1, 20'h32768, 1'b1, 5'b11111);
    conv("umax",    1'b0, 16'hFFFF, 1'b0, 20'h65535, 1'b0, 5'b11111);
    conv("zero",    1'b0, 16'h0000, 1'b1, 20'h00000, 1'b0, 5'b00001);
    conv("lz250",   1'b0, 16'h00FA, 1'b1, 20'h00250, 1'b0, 5'b00111);
    conv("posmax",  1'b0, 16'h7FFF, 1'b1, 20'h32767, 1'b0, 5'b11111);

    // Backpressure: result must stay frozen and no new request accepted.
    start(1'b0, 16'h3039, 1'b0, 1'b0);
    wait_done(1'b0, lat);
    chk("bp_lat", 64'(lat), 64'd16);
    check_res("bp_first", 1'b0, 20'h12345, 1'b0, 5'b11111);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 16'hFFFF - 16'(i), 1'b1, 1'b0);
      tick();
      check_res("bp_hold", 1'b0, 20'h12345, 1'b0, 5'b11111);
    end
    finish_hs("bp", 1'b0);
    tick();
    get_out(1'b0, ov, ir, b, sg, en);
    chk("bp_single_hs", 64'(ov), 64'd0);

    // Reset in the middle of SHIFT aborts immediately.
    start(1'b0, 16'h1234, 1'b0, 1'b1);
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    get_out(1'b0, ov, ir, b, sg, en);
    chk("midrst_ov", 64'(ov), 64'd0);
    chk("midrst_bcd", 64'(b), 64'd0);
    chk("midrst_ir", 64'(ir), 64'd1);
    tick();
    rst_n = 1'b1;
    tick();
    conv("postrst", 1'b0, 16'h04D2, 1'b0, 20'h01234, 1'b0, 5'b01111);

    // Narrow instance.
    conv("w8_m128", 1'b1, 16'h0080, 1'b1, 20'h00128, 1'b1, 5'b00111);
    conv("w8_u255", 1'b1, 16'h00FF, 1'b0, 20'h00255, 1'b0, 5'b00111);
    conv("w8_neg1", 1'b1, 16'h00FF, 1'b1, 20'h00001, 1'b1, 5'b00001);

    // Random against the division-based reference model.
    for (int i = 0; i < 600; i++) begin
      rd = 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      model(1'b0, rd, rs, mb, ms, men);
      conv("rnd16", 1'b0, rd, rs, mb, ms, men);
    end
    for (int i = 0; i < 400; i++) begin
      rd = {8'h00, 8'($urandom)};
      rs = 1'($urandom_range(0, 1));
      model(1'b1, rd, rs, mb, ms, men);
      conv("rnd8", 1'b1, rd, rs, mb, ms, men);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
